mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access (MEM) stage of the 5-stage RV32I pipeline. Sits between the execute stage and write-back.
- Converts execute-stage load/store requests into a word-addressed, byte-enabled request/acknowledge transaction to the data memory or DDR3 controller front-end.
- Stalls upstream while a transaction is outstanding.
- Performs load alignment and sign/zero extension, selects the write-back result and registers the MEM/WB pipeline register.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address and program-counter width.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- i_ex_valid  in  1  execute-stage slot holds a real instruction
- i_ex_alu_result  in  DATA_WIDTH  ALU result / effective byte address
- i_ex_wr_data  in  DATA_WIDTH  store data (rs2)
- i_ex_dst_reg  in  REG_ADDR_WIDTH  destination register
- i_ex_pc_next  in  ADDR_WIDTH  PC+4, used by JAL/JALR
- i_ex_mem_rd  in  1  load
- i_ex_mem_wr  in  1  store
- i_ex_funct3  in  3  access size/sign
- i_ex_wb_en  in  1  register write enable
- i_ex_result_sel  in  2  write-back source
- o_stall  out  1  hold EX and all upstream stages
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  1 = write
- o_mem_addr  out  ADDR_WIDTH  word-aligned address
- o_mem_wdata  out  DATA_WIDTH  lane-replicated store data
- o_mem_be  out  4  byte enables
- i_mem_ack  in  1  request complete; i_mem_rdata valid this cycle
- i_mem_rdata  in  DATA_WIDTH  read word
- o_wb_valid  out  1  MEM/WB slot valid
- o_wb_en  out  1  register write enable
- o_wb_dst_reg  out  REG_ADDR_WIDTH  destination register
- o_wb_result  out  DATA_WIDTH  selected write-back value
- o_misaligned  out  1  misaligned-access flag

Behaviour:
- Reset is i_reset_n, synchronous and active-low, on clock i_clk. While reset is asserted:
  - state := IDLE
  - every o_mem_* output := 0
  - every o_wb_* output := 0, o_misaligned := 0
  - any outstanding request is abandoned; a late i_mem_ack is ignored in IDLE.
- Memory op = i_ex_valid & (i_ex_mem_rd | i_ex_mem_wr). If both rd and wr are set, the op is treated as a store.
- FSM has two states, IDLE and REQ.
  - IDLE, no memory op: the MEM/WB register loads from the EX inputs (valid, wb_en, dst_reg, result) in 1 cycle. o_stall = 0.
  - IDLE, memory op: latch the request, go to REQ, set o_mem_req := 1, o_wb_valid := 0. o_stall = 1 combinationally in this same cycle.
  - REQ: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata and o_mem_be are held stable until i_mem_ack. o_stall = ~i_mem_ack.
  - REQ with i_mem_ack: o_mem_req := 0; the MEM/WB register loads (load data or passthrough); o_wb_valid := 1; state := IDLE. EX inputs are not sampled for a new request on this cycle.
- i_mem_ack is permitted on the first REQ cycle. Minimum memory-op latency is 2 cycles; non-memory latency is 1 cycle.
- Address: o_mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Byte enables by funct3:
  - SB (0): be = 4'b0001 << addr[1:0]; the byte is replicated to all 4 lanes.
  - SH (1): be = addr[1] ? 4'b1100 : 4'b0011; the halfword is replicated to both halves.
  - SW (2): be = 4'b1111.
  - Loads drive be = 4'b1111.
  - funct3 values 3, 6 and 7 are treated as word accesses.
- Load extract: shifted = rdata >> (8*addr[1:0]).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: rdata unchanged.
- Result select: 00 = ALU result, 01 = extracted load data, 10 = zero-extended pc_next, 11 = 0.
- Stores complete with o_wb_valid = 1 and o_wb_en as supplied (normally 0).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- With the macro defined, misaligned halfword (addr[0] = 1) or word (addr[1:0] != 0) accesses:
  - issue no request and do not stall;
  - in 1 cycle the stage produces o_wb_valid = 1, o_wb_en = 0, o_misaligned = 1.
  - o_misaligned is 0 on every other cycle.
- Without the macro: the port stays present but is tied to 0. Low address bits outside the access size are ignored (halfword uses addr[1] only; word accesses are forced aligned).

Test Plan:
- ADD passthrough: valid = 1, result_sel = 00, alu = 0x1234, dst = 5 -> next cycle o_wb_valid = 1, o_wb_result = 0x1234, o_wb_dst_reg = 5, o_stall never asserted.
- SB: addr 0x103, data 0xAB -> o_mem_addr = 0x100, o_mem_be = 4'b1000, o_mem_wdata = 0xABABABAB, o_mem_we = 1. Ack after 3 cycles -> o_stall high for exactly 4 cycles, then one o_wb_valid pulse.
- Loads with rdata 0x80F0_7F81:
  - LB @ +0 -> 0xFFFFFF81
  - LBU @ +0 -> 0x00000081
  - LH @ +2 -> 0xFFFF80F0
  - LHU @ +2 -> 0x000080F0
  - LW -> 0x80F07F81
- Ack on the first REQ cycle -> 2-cycle op. Next instruction is a load issued back-to-back -> o_mem_req is low for exactly 1 cycle between the two requests.
- Reset asserted in REQ with no ack -> next cycle o_mem_req = 0, o_stall = 0, o_wb_valid = 0. A later i_mem_ack produces no o_wb_valid.
- JAL: result_sel = 10, pc_next = 0x48 -> o_wb_result = 0x48. With MEM_MISALIGN_TRAP_EN, LW @ 0x102 -> o_misaligned = 1, o_mem_req stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage - sequences load/store request/ack transactions, aligns and extends
// load data, selects the write-back value and registers MEM/WB. Optional trap build: MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_ex_valid,
  input  logic [DATA_WIDTH-1:0]     i_ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_ex_wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_dst_reg,
  input  logic [ADDR_WIDTH-1:0]     i_ex_pc_next,
  input  logic                      i_ex_mem_rd,
  input  logic                      i_ex_mem_wr,
  input  logic [2:0]                i_ex_funct3,
  input  logic                      i_ex_wb_en,
  input  logic [1:0]                i_ex_result_sel,
  output logic                      o_stall,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  output logic [3:0]                o_mem_be,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_wb_valid,
  output logic                      o_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_dst_reg,
  output logic [DATA_WIDTH-1:0]     o_wb_result,
  output logic                      o_misaligned
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;

  // Byte offset actually honoured: halfwords look at addr[1] only, words are forced aligned.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                      input logic [DATA_WIDTH-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rdata);
    logic [DATA_WIDTH-1:0] s;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wb_mux(input logic [1:0] sel,
                                                  input logic [DATA_WIDTH-1:0] alu,
                                                  input logic [DATA_WIDTH-1:0] ld,
                                                  input logic [ADDR_WIDTH-1:0] pc);
    case (sel)
      SEL_ALU:  return alu;
      SEL_LOAD: return ld;
      SEL_PC:   return DATA_WIDTH'(pc);
      default:  return '0;
    endcase
  endfunction

  state_t                    state_q, state_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]                mem_be_q, mem_be_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dst_q, wb_dst_d;
  logic [DATA_WIDTH-1:0]     wb_result_q, wb_result_d;
  logic                      misaligned_q, misaligned_d;

  // Instruction context held across the outstanding transaction.
  logic [2:0]                req_f3_q, req_f3_d;
  logic [1:0]                req_off_q, req_off_d;
  logic [1:0]                req_sel_q, req_sel_d;
  logic [DATA_WIDTH-1:0]     req_alu_q, req_alu_d;
  logic [ADDR_WIDTH-1:0]     req_pc_q, req_pc_d;
  logic [REG_ADDR_WIDTH-1:0] req_dst_q, req_dst_d;
  logic                      req_wb_en_q, req_wb_en_d;

  logic       mem_op;
  logic       ex_misaligned;
  logic [1:0] ex_off;

  always_comb begin
    mem_op = i_ex_valid & (i_ex_mem_rd | i_ex_mem_wr);
    ex_off = eff_offset(i_ex_funct3, i_ex_alu_result[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    ex_misaligned = mem_op &
                    (((i_ex_funct3[1:0] == 2'b01) & i_ex_alu_result[0]) |
                     (i_ex_funct3[1] & (i_ex_alu_result[1:0] != 2'b00)));
`else
    ex_misaligned = 1'b0;
`endif
  end

  always_comb begin
    if (!i_reset_n)
      o_stall = 1'b0;
    else if (state_q == IDLE)
      o_stall = mem_op & ~ex_misaligned;
    else
      o_stall = ~i_mem_ack;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    wb_valid_d   = wb_valid_q;
    wb_en_d      = wb_en_q;
    wb_dst_d     = wb_dst_q;
    wb_result_d  = wb_result_q;
    misaligned_d = 1'b0;
    req_f3_d     = req_f3_q;
    req_off_d    = req_off_q;
    req_sel_d    = req_sel_q;
    req_alu_d    = req_alu_q;
    req_pc_d     = req_pc_q;
    req_dst_d    = req_dst_q;
    req_wb_en_d  = req_wb_en_q;

    case (state_q)
      IDLE: begin
        if (mem_op && !ex_misaligned) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = i_ex_mem_wr;
          mem_addr_d  = {i_ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
          mem_be_d    = i_ex_mem_wr ? store_be(i_ex_funct3, ex_off) : 4'b1111;
          mem_wdata_d = i_ex_mem_wr ? store_data(i_ex_funct3, i_ex_wr_data) : '0;
          wb_valid_d  = 1'b0;
          req_f3_d    = i_ex_funct3;
          req_off_d   = ex_off;
          req_sel_d   = i_ex_result_sel;
          req_alu_d   = i_ex_alu_result;
          req_pc_d    = i_ex_pc_next;
          req_dst_d   = i_ex_dst_reg;
          req_wb_en_d = i_ex_wb_en;
        end else if (ex_misaligned) begin
          wb_valid_d   = 1'b1;
          wb_en_d      = 1'b0;
          wb_dst_d     = i_ex_dst_reg;
          wb_result_d  = i_ex_alu_result;
          misaligned_d = 1'b1;
        end else begin
          wb_valid_d  = i_ex_valid;
          wb_en_d     = i_ex_valid & i_ex_wb_en;
          wb_dst_d    = i_ex_dst_reg;
          wb_result_d = wb_mux(i_ex_result_sel, i_ex_alu_result, '0, i_ex_pc_next);
        end
      end
      REQ: begin
        // Request fields stay frozen until the acknowledge retires the access.
        if (i_mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          wb_valid_d  = 1'b1;
          wb_en_d     = req_wb_en_q;
          wb_dst_d    = req_dst_q;
          wb_result_d = wb_mux(req_sel_q, req_alu_q,
                               load_extract(req_f3_q, req_off_q, i_mem_rdata), req_pc_q);
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'b0000;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_dst_q     <= '0;
      wb_result_q  <= '0;
      misaligned_q <= 1'b0;
      req_f3_q     <= 3'd0;
      req_off_q    <= 2'd0;
      req_sel_q    <= 2'd0;
      req_alu_q    <= '0;
      req_pc_q     <= '0;
      req_dst_q    <= '0;
      req_wb_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_dst_q     <= wb_dst_d;
      wb_result_q  <= wb_result_d;
      misaligned_q <= misaligned_d;
      req_f3_q     <= req_f3_d;
      req_off_q    <= req_off_d;
      req_sel_q    <= req_sel_d;
      req_alu_q    <= req_alu_d;
      req_pc_q     <= req_pc_d;
      req_dst_q    <= req_dst_d;
      req_wb_en_q  <= req_wb_en_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_be     = mem_be_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_en      = wb_en_q;
  assign o_wb_dst_reg = wb_dst_q;
  assign o_wb_result  = wb_result_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instruction stream, memory responder with programmable ack
// latency, and scoreboard queues for memory requests and MEM/WB results.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_wd = '0;
  logic [4:0]  ex_dst = '0;
  logic [31:0] ex_pcn = '0;
  logic        ex_rd = 1'b0;
  logic        ex_wr = 1'b0;
  logic [2:0]  ex_f3 = '0;
  logic        ex_wben = 1'b0;
  logic [1:0]  ex_sel = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        o_stall, o_mem_req, o_mem_we, o_wb_valid, o_wb_en, o_misaligned;
  logic [31:0] o_mem_addr, o_mem_wdata, o_wb_result;
  logic [3:0]  o_mem_be;
  logic [4:0]  o_wb_dst_reg;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ex_valid(ex_valid), .i_ex_alu_result(ex_alu), .i_ex_wr_data(ex_wd),
    .i_ex_dst_reg(ex_dst), .i_ex_pc_next(ex_pcn), .i_ex_mem_rd(ex_rd),
    .i_ex_mem_wr(ex_wr), .i_ex_funct3(ex_f3), .i_ex_wb_en(ex_wben),
    .i_ex_result_sel(ex_sel), .o_stall(o_stall), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_en(o_wb_en), .o_wb_dst_reg(o_wb_dst_reg),
    .o_wb_result(o_wb_result), .o_misaligned(o_misaligned)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] res;
    logic        en;
    logic        mis;
    logic        chk_res;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        auto_ack   = 1'b1;
  logic        ack_inject = 1'b0;
  int          mem_lat    = 0;
  logic [31:0] mem_data   = '0;
  int          wait_cnt   = 0;
  int          low_cnt    = 1000;
  int          last_gap   = -1;
  logic        prev_req   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks after mem_lat wait cycles and checks the request it retires.
  initial begin
    req_exp_t r;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = mem_data;
      if (ack_inject) begin
        mem_ack = 1'b1;
      end else if (auto_ack && o_mem_req && !mem_ack) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_unexpected_req: got addr 0x%08h we %0d, required no request", o_mem_addr, o_mem_we);
          end else begin
            r = req_q.pop_front();
            check("mem_we",    32'(o_mem_we), 32'(r.we));
            check("mem_addr",  o_mem_addr,    r.addr);
            check("mem_be",    32'(o_mem_be), 32'(r.be));
            if (r.we) check("mem_wdata", o_mem_wdata, r.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // Write-back monitor plus request-gap tracking.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_wb_valid) begin
        if (wb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: got valid dst %0d result 0x%08h, required no write-back", o_wb_dst_reg, o_wb_result);
        end else begin
          e = wb_q.pop_front();
          check("wb_dst", 32'(o_wb_dst_reg), 32'(e.dst));
          check("wb_en",  32'(o_wb_en),      32'(e.en));
          check("wb_mis", 32'(o_misaligned), 32'(e.mis));
          if (e.chk_res) check("wb_result", o_wb_result, e.res);
        end
      end
      if (o_mem_req) begin
        if (!prev_req) last_gap = low_cnt;
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_req = o_mem_req;
    end
  end

  // op: 0 none, 1 load, 2 store, 3 rd+wr. Returns the number of cycles EX was held.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pcn, input logic [4:0] dst,
                       input logic wben, input logic [1:0] sel, input int lat,
                       input logic [31:0] rdata, input logic [31:0] exp_res,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic exp_mis, output int stalls);
    bit done;
    mem_lat  = lat;
    mem_data = rdata;
    ex_valid = 1'b1;
    ex_alu   = alu;
    ex_wd    = wd;
    ex_pcn   = pcn;
    ex_dst   = dst;
    ex_rd    = op[0];
    ex_wr    = op[1];
    ex_f3    = f3;
    ex_wben  = wben;
    ex_sel   = sel;
    wb_q.push_back('{dst, exp_res, exp_mis ? 1'b0 : wben, exp_mis, !exp_mis});
    if (op != 2'd0 && !exp_mis)
      req_q.push_back('{op[1], {alu[31:2], 2'b00}, exp_wdata, exp_be});
    stalls = 0;
    done   = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!o_stall) done = 1;
      else stalls++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got stall for %0d cycles, required release", stalls);
    end
    @(posedge clk);
    #2;
    ex_valid = 1'b0;
    ex_rd    = 1'b0;
    ex_wr    = 1'b0;
  endtask

  localparam logic [31:0] RD = 32'h80F0_7F81;

  initial begin
    int st;
    repeat (3) @(negedge clk);
    check("rst_mem_req",   32'(o_mem_req),    0);
    check("rst_mem_we",    32'(o_mem_we),     0);
    check("rst_mem_addr",  o_mem_addr,        0);
    check("rst_mem_be",    32'(o_mem_be),     0);
    check("rst_mem_wdata", o_mem_wdata,       0);
    check("rst_wb_valid",  32'(o_wb_valid),   0);
    check("rst_wb_en",     32'(o_wb_en),      0);
    check("rst_wb_result", o_wb_result,       0);
    check("rst_misalign",  32'(o_misaligned), 0);
    check("rst_stall",     32'(o_stall),      0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // ALU passthrough and PC / zero selects
    issue(2'd0, 3'd0, 32'h1234, 0, 0, 5'd5, 1, 2'b00, 0, 0, 32'h1234, 4'h0, 0, 0, st);
    check("add_stall", st, 0);
    issue(2'd0, 3'd0, 32'h999, 0, 32'h48, 5'd1, 1, 2'b10, 0, 0, 32'h48, 4'h0, 0, 0, st);
    issue(2'd0, 3'd0, 32'h777, 0, 32'h50, 5'd9, 1, 2'b11, 0, 0, 32'h0, 4'h0, 0, 0, st);
    repeat (2) @(posedge clk);
    #2;

    // Stores
    issue(2'd2, 3'd0, 32'h103, 32'hAB, 0, 5'd0, 0, 2'b00, 3, 0, 32'h103, 4'b1000, 32'hABABABAB, 0, st);
    check("sb_stall_cycles", st, 4);
    issue(2'd2, 3'd1, 32'h202, 32'h1234BEEF, 0, 5'd0, 0, 2'b00, 1, 0, 32'h202, 4'b1100, 32'hBEEFBEEF, 0, st);
    check("sh_stall_cycles", st, 2);
    issue(2'd2, 3'd1, 32'h200, 32'h0000CAFE, 0, 5'd0, 0, 2'b00, 0, 0, 32'h200, 4'b0011, 32'hCAFECAFE, 0, st);
    issue(2'd2, 3'd2, 32'h204, 32'hDEADBEEF, 0, 5'd0, 0, 2'b00, 0, 0, 32'h204, 4'b1111, 32'hDEADBEEF, 0, st);
    check("sw_stall_cycles", st, 1);
    issue(2'd3, 3'd0, 32'h101, 32'h5A, 0, 5'd3, 0, 2'b00, 2, 0, 32'h101, 4'b0010, 32'h5A5A5A5A, 0, st);

    // Loads, back-to-back with first-cycle ack
    issue(2'd1, 3'd0, 32'h300, 0, 0, 5'd10, 1, 2'b01, 0, RD, 32'hFFFFFF81, 4'b1111, 0, 0, st);
    check("ld_fast_stall", st, 1);
    issue(2'd1, 3'd4, 32'h300, 0, 0, 5'd11, 1, 2'b01, 0, RD, 32'h00000081, 4'b1111, 0, 0, st);
    check("ld_req_gap", last_gap, 1);
    issue(2'd1, 3'd1, 32'h302, 0, 0, 5'd12, 1, 2'b01, 0, RD, 32'hFFFF80F0, 4'b1111, 0, 0, st);
    issue(2'd1, 3'd5, 32'h302, 0, 0, 5'd13, 1, 2'b01, 2, RD, 32'h000080F0, 4'b1111, 0, 0, st);
    issue(2'd1, 3'd2, 32'h300, 0, 0, 5'd14, 1, 2'b01, 0, RD, 32'h80F07F81, 4'b1111, 0, 0, st);
    issue(2'd1, 3'd4, 32'h301, 0, 0, 5'd15, 1, 2'b01, 0, RD, 32'h0000007F, 4'b1111, 0, 0, st);
    issue(2'd1, 3'd0, 32'h303, 0, 0, 5'd16, 1, 2'b01, 1, RD, 32'hFFFFFF80, 4'b1111, 0, 0, st);
    issue(2'd1, 3'd1, 32'h300, 0, 0, 5'd17, 1, 2'b01, 0, RD, 32'h00007F81, 4'b1111, 0, 0, st);

`ifdef MEM_MISALIGN_TRAP_EN
    issue(2'd1, 3'd2, 32'h102, 0, 0, 5'd18, 1, 2'b01, 0, RD, 32'h0, 4'b1111, 0, 1, st);
    check("mis_lw_stall", st, 0);
    issue(2'd2, 3'd1, 32'h105, 32'h1, 0, 5'd0, 0, 2'b00, 0, 0, 32'h0, 4'b0000, 0, 1, st);
    check("mis_sh_stall", st, 0);
`else
    issue(2'd1, 3'd2, 32'h102, 0, 0, 5'd18, 1, 2'b01, 0, RD, 32'h80F07F81, 4'b1111, 0, 0, st);
    check("lw_unaligned_stall", st, 1);
    issue(2'd1, 3'd1, 32'h301, 0, 0, 5'd19, 1, 2'b01, 0, RD, 32'h00007F81, 4'b1111, 0, 0, st);
    issue(2'd2, 3'd3, 32'h30F, 32'h01020304, 0, 5'd0, 0, 2'b00, 0, 0, 32'h30F, 4'b1111, 32'h01020304, 0, st);
`endif
    repeat (2) @(posedge clk);
    #2;

    // Reset while a load is outstanding; a late ack must be ignored
    auto_ack = 1'b0;
    ex_valid = 1'b1; ex_rd = 1'b1; ex_f3 = 3'd2; ex_alu = 32'h400;
    ex_dst = 5'd7; ex_sel = 2'b01; ex_wben = 1'b1;
    @(posedge clk);
    #2;
    ex_valid = 1'b0; ex_rd = 1'b0;
    @(negedge clk);
    check("pre_rst_req",   32'(o_mem_req), 1);
    check("pre_rst_stall", 32'(o_stall),   1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req",      32'(o_mem_req),  0);
    check("midrst_stall",    32'(o_stall),    0);
    check("midrst_wb_valid", 32'(o_wb_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    ack_inject = 1'b1;
    @(posedge clk);
    #2;
    ack_inject = 1'b0;
    @(negedge clk);
    check("late_ack_seen", 32'(mem_ack), 1);
    @(negedge clk);
    check("late_ack_wb_valid", 32'(o_wb_valid), 0);
    check("late_ack_req",      32'(o_mem_req),  0);
    auto_ack = 1'b1;

    repeat (4) @(posedge clk);
    #2;
    check("wb_queue_drained",  wb_q.size(),  0);
    check("req_queue_drained", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
